// File: rtl/imem_prog_controller.sv
// Purpose: reloads the instruction memory from a framed UART byte stream while the core is held.
// Latency: each IMEM write pulse comes one cycle after the 4th byte of its word; done/err come one cycle after the deciding event.
// Backpressure: none; every rx_valid byte is consumed in the cycle it arrives.
//
// Frame: N_lo, N_hi, N x 4 data bytes (LSB first per word), then one checksum byte.
// The checksum is the XOR of the data bytes only.
// Words are written to consecutive word addresses starting at 0.
// memcon_prog_ena holds the fetch stage and clears its PC whenever a load is in progress.

module imem_prog_controller #(
  parameter int IMEM_WORDS     = 1024,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        memcon_prog_ena,
  output logic        imem_en,
  output logic [3:0]  imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        prog_done,
  output logic        prog_err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_CHECKSUM = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0]  ERR_OVERSIZE = 2'd3;

  localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t       state;
  state_t       state_nxt;

  // Header and word-assembly state
  logic [7:0]   n_lo;
  logic [15:0]  n_words;
  logic [15:0]  word_idx;
  logic [1:0]   byte_idx;
  logic [23:0]  shreg;
  logic [7:0]   csum;
  logic [31:0]  to_cnt;

  // Decisions made this cycle, registered into the outputs at the next edge
  logic         start_acc;
  logic         done_nxt;
  logic         err_nxt;
  logic [1:0]   err_code_nxt;
  logic         wr_nxt;
  logic         to_expire;
  logic [15:0]  len_full;
  logic [31:0]  len_ext;

  // The header length as it stands once the high byte arrives
  assign len_full = {rx_data, n_lo};
  assign len_ext  = {16'd0, len_full};

  // The fetch stage is held for the whole time the sequencer is away from IDLE
  assign memcon_prog_ena = (state != S_IDLE);

  // Timeout fires on an idle cycle whose counter value has reached the limit
  assign to_expire = (state != S_IDLE) && !rx_valid && (to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = ERR_NONE;
    wr_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (prog_start) begin
          start_acc = 1'b1;
          state_nxt = S_LEN0;
        end
      end

      S_LEN0: begin
        if (rx_valid) begin
          state_nxt = S_LEN1;
        end
      end

      S_LEN1: begin
        if (rx_valid) begin
          if (len_ext > MAX_WORDS) begin
            state_nxt    = S_IDLE;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_OVERSIZE;
          end else if (len_full == 16'd0) begin
            state_nxt = S_CHECK;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (rx_valid && (byte_idx == 2'd3)) begin
          wr_nxt = 1'b1;
          if ((word_idx + 16'd1) == n_words) begin
            state_nxt = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (rx_valid) begin
          state_nxt = S_IDLE;
          if (rx_data == csum) begin
            done_nxt = 1'b1;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CHECKSUM;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Timeout only happens on a cycle with no byte, so it never competes with the byte decisions above
    if (to_expire) begin
      state_nxt    = S_IDLE;
      err_nxt      = 1'b1;
      err_code_nxt = ERR_TIMEOUT;
    end
  end

  // Header capture, word assembly, checksum accumulation and the inter-byte timer
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      n_lo     <= 8'd0;
      n_words  <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      shreg    <= 24'd0;
      csum     <= 8'd0;
      to_cnt   <= 32'd0;
    end else if (start_acc) begin
      n_lo     <= 8'd0;
      n_words  <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      shreg    <= 24'd0;
      csum     <= 8'd0;
      to_cnt   <= 32'd0;
    end else if (state != S_IDLE) begin
      // The byte cycle itself counts as cycle 0, so the first quiet cycle after it reads 1
      if (rx_valid) begin
        to_cnt <= 32'd1;
      end else if (to_expire) begin
        to_cnt <= 32'd0;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end

      if (rx_valid) begin
        case (state)
          S_LEN0: begin
            n_lo <= rx_data;
          end
          S_LEN1: begin
            n_words <= len_full;
          end
          S_DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            // Lane 3 is taken straight from rx_data into the write data register
            case (byte_idx)
              2'd0: shreg[7:0]   <= rx_data;
              2'd1: shreg[15:8]  <= rx_data;
              2'd2: shreg[23:16] <= rx_data;
              default: word_idx  <= word_idx + 16'd1;
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Registered IMEM write port and status pulses; address/data hold between writes
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      imem_en   <= 1'b0;
      imem_we   <= 4'h0;
      imem_addr <= 32'd0;
      imem_din  <= 32'd0;
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      imem_en   <= wr_nxt;
      imem_we   <= wr_nxt ? 4'hF : 4'h0;
      if (wr_nxt) begin
        imem_addr <= {14'd0, word_idx, 2'b00};
        imem_din  <= {rx_data, shreg};
      end
      prog_done <= done_nxt;
      prog_err  <= err_nxt;
      if (start_acc) begin
        err_code <= ERR_NONE;
      end else if (err_nxt) begin
        err_code <= err_code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_imem_prog_controller.sv
// Directed bench for imem_prog_controller: normal load, checksum error, oversize header,
// timeout, zero-length load, ignored requests and reset in the middle of a load.
// Runs with TIMEOUT_CYCLES=16 and IMEM_WORDS=1024.

module tb_imem_prog_controller;

  logic        clk = 1'b0;
  logic        Rst;
  logic        prog_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        memcon_prog_ena;
  logic        imem_en;
  logic [3:0]  imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        prog_done;
  logic        prog_err;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  imem_prog_controller #(
    .IMEM_WORDS(1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .prog_start(prog_start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .memcon_prog_ena(memcon_prog_ena),
    .imem_en(imem_en),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_din(imem_din),
    .prog_done(prog_done),
    .prog_err(prog_err),
    .err_code(err_code)
  );

  // Counts IMEM write cycles
  always @(posedge clk) begin
    if (imem_en === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    prog_start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tick();
    tick();
    n_vec++;
    if ({memcon_prog_ena, imem_en, imem_we, prog_done, prog_err, err_code} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0", {memcon_prog_ena, imem_en, imem_we, prog_done, prog_err, err_code});
    end
    n_vec++;
    if (imem_addr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_addr: got %h expected 0", imem_addr);
    end
    n_vec++;
    if (imem_din !== 32'd0) begin
      n_err++;
      $display("FAIL reset_din: got %h expected 0", imem_din);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignore();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    tick();
    n_vec++;
    if ({memcon_prog_ena, prog_done, prog_err} !== 3'b000 || wr_count !== w0) begin
      n_err++;
      $display("FAIL idle_rx: got ena/done/err %b writes %0d expected 000 writes 0",
               {memcon_prog_ena, prog_done, prog_err}, wr_count - w0);
    end
  endtask

  // N=2, words 0x00000013 and 0xDEADBEEF, checksum 0x31 (or a corrupted one)
  task automatic load_two_words(input logic [7:0] ck);
    n_vec++;
    if (memcon_prog_ena !== 1'b0) begin
      n_err++;
      $display("FAIL ena_before_start: got %b expected 0", memcon_prog_ena);
    end
    pulse_start();
    n_vec++;
    if (memcon_prog_ena !== 1'b1) begin
      n_err++;
      $display("FAIL ena_after_start: got %b expected 1", memcon_prog_ena);
    end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    n_vec++;
    if (imem_en !== 1'b0) begin
      n_err++;
      $display("FAIL early_write: got %b expected 0", imem_en);
    end
    send_byte(8'h00);
    n_vec++;
    if ({imem_en, imem_we} !== 5'b1_1111 || imem_addr !== 32'h0 || imem_din !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL write0: got en/we %b addr %h din %h expected 11111 0 00000013",
               {imem_en, imem_we}, imem_addr, imem_din);
    end
    // Byte 0 of word 1 lands in the same cycle as the word 0 write pulse
    send_byte(8'hEF);
    n_vec++;
    if ({imem_en, imem_we} !== 5'b0_0000 || imem_addr !== 32'h0 || imem_din !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL write0_hold: got en/we %b addr %h din %h expected 00000 0 00000013",
               {imem_en, imem_we}, imem_addr, imem_din);
    end
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    n_vec++;
    if ({imem_en, imem_we} !== 5'b1_1111 || imem_addr !== 32'h4 || imem_din !== 32'hDEAD_BEEF || memcon_prog_ena !== 1'b1) begin
      n_err++;
      $display("FAIL write1: got en/we %b addr %h din %h ena %b expected 11111 4 deadbeef 1",
               {imem_en, imem_we}, imem_addr, imem_din, memcon_prog_ena);
    end
    send_byte(ck);
  endtask

  task automatic test_load_ok();
    int w0;
    w0 = wr_count;
    load_two_words(8'h31);
    n_vec++;
    if ({prog_done, prog_err, memcon_prog_ena, err_code} !== 5'b10000) begin
      n_err++;
      $display("FAIL load_done: got done/err/ena/code %b expected 10000",
               {prog_done, prog_err, memcon_prog_ena, err_code});
    end
    tick();
    n_vec++;
    if (prog_done !== 1'b0 || wr_count - w0 !== 2) begin
      n_err++;
      $display("FAIL done_pulse_len: got done %b writes %0d expected 0 writes 2", prog_done, wr_count - w0);
    end
  endtask

  task automatic test_bad_checksum();
    int w0;
    w0 = wr_count;
    load_two_words(8'h30);
    n_vec++;
    if ({prog_done, prog_err, memcon_prog_ena, err_code} !== 5'b01001) begin
      n_err++;
      $display("FAIL csum_err: got done/err/ena/code %b expected 01001",
               {prog_done, prog_err, memcon_prog_ena, err_code});
    end
    tick();
    n_vec++;
    if (prog_err !== 1'b0 || err_code !== 2'd1 || wr_count - w0 !== 2) begin
      n_err++;
      $display("FAIL csum_hold: got err %b code %0d writes %0d expected 0 1 2", prog_err, err_code, wr_count - w0);
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_count;
    pulse_start();
    n_vec++;
    if (err_code !== 2'd0) begin
      n_err++;
      $display("FAIL code_clear_on_start: got %0d expected 0", err_code);
    end
    send_byte(8'h01);
    n_vec++;
    if (prog_err !== 1'b0) begin
      n_err++;
      $display("FAIL oversize_early: got %b expected 0", prog_err);
    end
    send_byte(8'h04);
    n_vec++;
    if ({prog_err, err_code, memcon_prog_ena, imem_en} !== 5'b11100 || wr_count !== w0) begin
      n_err++;
      $display("FAIL oversize: got err/code/ena/en %b writes %0d expected 11100 writes 0",
               {prog_err, err_code, memcon_prog_ena, imem_en}, wr_count - w0);
    end
    tick();
  endtask

  // N=1024 is exactly full capacity: accepted, then left to time out with no data
  task automatic test_max_len();
    int k;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    n_vec++;
    if (memcon_prog_ena !== 1'b1 || prog_err !== 1'b0) begin
      n_err++;
      $display("FAIL max_len_accept: got ena %b err %b expected 1 0", memcon_prog_ena, prog_err);
    end
    k = 0;
    while (prog_err !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (k !== 15 || err_code !== 2'd2) begin
      n_err++;
      $display("FAIL max_len_timeout: got wait %0d code %0d expected 15 2", k, err_code);
    end
    tick();
  endtask

  task automatic test_timeout();
    int w0;
    int k;
    w0 = wr_count;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    // Now one cycle after the last byte; the error is due 16 cycles after it
    k = 0;
    while (prog_err !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (k !== 15) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles after last byte expected 16", k + 1);
    end
    n_vec++;
    if (err_code !== 2'd2 || memcon_prog_ena !== 1'b0 || prog_done !== 1'b0 || wr_count !== w0) begin
      n_err++;
      $display("FAIL timeout_state: got code %0d ena %b done %b writes %0d expected 2 0 0 0",
               err_code, memcon_prog_ena, prog_done, wr_count - w0);
    end
    tick();
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    // A start request mid-load must be ignored
    pulse_start();
    tick();
    n_vec++;
    if (memcon_prog_ena !== 1'b1 || prog_done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_ignored: got ena %b done %b expected 1 0", memcon_prog_ena, prog_done);
    end
    send_byte(8'h00);
    n_vec++;
    if ({prog_done, prog_err, memcon_prog_ena} !== 3'b100 || wr_count !== w0) begin
      n_err++;
      $display("FAIL zero_len_done: got done/err/ena %b writes %0d expected 100 writes 0",
               {prog_done, prog_err, memcon_prog_ena}, wr_count - w0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int w0;
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    Rst = 1'b1;
    tick();
    n_vec++;
    if ({memcon_prog_ena, imem_en, imem_we, prog_done, prog_err, err_code} !== 10'd0
        || imem_addr !== 32'd0 || imem_din !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: got ctrl %b addr %h din %h expected all 0",
               {memcon_prog_ena, imem_en, imem_we, prog_done, prog_err, err_code}, imem_addr, imem_din);
    end
    Rst = 1'b0;
    tick();
    w0 = wr_count;
    // Fresh single-word load: A1 B2 C3 D4, checksum A1^B2^C3^D4 = 0x04
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    n_vec++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h0 || imem_din !== 32'hD4C3_B2A1) begin
      n_err++;
      $display("FAIL fresh_write: got en %b addr %h din %h expected 1 0 d4c3b2a1", imem_en, imem_addr, imem_din);
    end
    send_byte(8'h04);
    n_vec++;
    if (prog_done !== 1'b1 || prog_err !== 1'b0 || wr_count - w0 !== 1) begin
      n_err++;
      $display("FAIL fresh_done: got done %b err %b writes %0d expected 1 0 1", prog_done, prog_err, wr_count - w0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_load_ok();
    test_bad_checksum();
    test_oversize();
    test_max_len();
    test_timeout();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
